// File: rtl/retire_trace_pkg.sv
// Shared field layout, trace type codes and beat-state encoding for the retire trace writer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package retire_trace_pkg;

  // Bit offsets within the 70-bit inst_retire bus.
  localparam int RT_PC_LSB    = 0;
  localparam int RT_WDATA_LSB = 32;
  localparam int RT_WADDR_LSB = 64;
  localparam int RT_EN_BIT    = 69;

  // A stored record drops rf_en, which is implied by the capture itself.
  localparam int RT_REC_W = 69;

  localparam logic [7:0] TRACE_TYPE_RF = 8'h01;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PC   = 2'd1,
    DATA = 2'd2
  } beat_state_e;

  // Header beat: type code in the top byte, destination register in the low bits.
  function automatic logic [31:0] rf_header(input logic [4:0] waddr);
    return {TRACE_TYPE_RF, 19'd0, waddr};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with wrap-bit pointers and a registered occupancy count.
// Latency: a push is visible at the head the cycle after the write edge; no bypass.
// Backpressure: caller must only push when !full or when popping in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Full when the indices match but the wrap bits differ.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  // Pointer and occupancy update; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_writer.sv
// Captures qualifying register-file retires and streams each as three 32-bit beats (HDR, PC, DATA).
// Latency: one cycle from the retire edge to out_valid; one beat per cycle under constant out_ready.
// Backpressure: out_ready stalls the beat in place; captures arriving while full are dropped and counted.
module retire_trace_writer
  import retire_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit SKIP_ZERO = 1'b1,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic          sys_clk,
  input  logic          sys_reset_n,
  input  logic [69:0]   inst_retire,
  input  logic          trace_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic [31:0]   drop_cnt,
  output logic [LW-1:0] fifo_level
);

  logic [4:0]          ret_waddr;
  logic                capture;
  logic                push_ok;
  logic                pop;
  logic                hs;
  logic                fifo_full;
  logic                fifo_empty;
  logic [RT_REC_W-1:0] head;
  logic [31:0]         head_pc;
  logic [31:0]         head_wdata;
  logic [4:0]          head_waddr;
  beat_state_e         state_q;
  beat_state_e         state_d;

  assign ret_waddr = inst_retire[RT_WADDR_LSB +: 5];
  assign capture   = trace_en && inst_retire[RT_EN_BIT] &&
                     (!SKIP_ZERO || (ret_waddr != 5'd0));

  assign out_valid = !fifo_empty;
  assign hs        = out_valid && out_ready;
  // Only the DATA handshake retires the head, so a record is never split.
  assign pop       = hs && (state_q == DATA);
  // A full FIFO still takes the capture when the head leaves in the same cycle.
  assign push_ok   = capture && (!fifo_full || pop);

  trace_fifo #(
    .WIDTH (RT_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (sys_clk),
    .rst_n    (sys_reset_n),
    .push     (push_ok),
    .push_dat (inst_retire[RT_REC_W-1:0]),
    .pop      (pop),
    .head     (head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head_pc    = head[RT_PC_LSB    +: 32];
  assign head_wdata = head[RT_WDATA_LSB +: 32];
  assign head_waddr = head[RT_WADDR_LSB +: 5];

  // Beat-state register; reset returns to HDR so any partial record is abandoned.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q <= HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Beat selection and advance; outputs are zero whenever nothing is stored.
  always_comb begin
    state_d  = state_q;
    out_data = 32'd0;
    out_last = 1'b0;
    if (out_valid) begin
      case (state_q)
        HDR: begin
          out_data = rf_header(head_waddr);
          if (hs) state_d = PC;
        end
        PC: begin
          out_data = head_pc;
          if (hs) state_d = DATA;
        end
        DATA: begin
          out_data = head_wdata;
          out_last = 1'b1;
          if (hs) state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end
  end

  // Saturating count of captures rejected because the FIFO had no room.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      drop_cnt <= 32'd0;
    end else if (capture && !push_ok && (drop_cnt != 32'hFFFF_FFFF)) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_retire_trace_writer.sv
// Self-checking bench: queue-based record model checked every cycle plus literal spot checks.
// Latency: n/a.
// Backpressure: out_ready driven both fixed and randomly.
module tb_retire_trace_writer;

  localparam int DEPTH = 16;

  logic        sys_clk;
  logic        sys_reset_n;
  logic [69:0] inst_retire;
  logic        trace_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [31:0] drop_cnt;
  logic [4:0]  fifo_level;

  // Second instance keeps x0 writes, used only for the SKIP_ZERO=0 header check.
  logic [69:0] nz_retire;
  logic        nz_valid;
  logic [31:0] nz_data;
  logic        nz_last;
  logic [31:0] nz_drop;
  logic [4:0]  nz_level;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;

  // Model state: stored records in order, beats already sent of the head, drop count.
  logic [68:0] mq[$];
  int          m_beat = 0;
  logic [31:0] m_drop = 0;

  retire_trace_writer #(.DEPTH(DEPTH), .SKIP_ZERO(1'b1)) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .inst_retire (inst_retire),
    .trace_en    (trace_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .drop_cnt    (drop_cnt),
    .fifo_level  (fifo_level)
  );

  retire_trace_writer #(.DEPTH(DEPTH), .SKIP_ZERO(1'b0)) dut_nz (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .inst_retire (nz_retire),
    .trace_en    (1'b1),
    .out_valid   (nz_valid),
    .out_ready   (1'b1),
    .out_data    (nz_data),
    .out_last    (nz_last),
    .drop_cnt    (nz_drop),
    .fifo_level  (nz_level)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [69:0] mk_ret(input logic [31:0] pc, input logic [31:0] wd, input logic [4:0] wa);
    return {1'b1, wa, wd, pc};
  endfunction

  function automatic logic [31:0] beat_of(input logic [68:0] rec, input int b);
    logic [31:0] w;
    case (b)
      0:       w = {8'h01, 19'd0, rec[68:64]};
      1:       w = rec[31:0];
      default: w = rec[63:32];
    endcase
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_beat = 0;
    m_drop = 0;
  endtask

  // Every cycle: compare outputs against the model, then advance the model to the next edge.
  always @(negedge sys_clk) begin
    if (sys_reset_n) begin
      bit          hs;
      bit          popped;
      bit          cap;
      int          sz;
      check("out_valid", out_valid, mq.size() != 0);
      check("fifo_level", fifo_level, mq.size());
      check("drop_cnt", drop_cnt, m_drop);
      if (mq.size() != 0) begin
        check("out_data", out_data, beat_of(mq[0], m_beat));
        check("out_last", out_last, m_beat == 2);
      end else begin
        check("idle_data", out_data, 0);
      end
      if (out_valid && out_ready) hs_cnt++;
      hs     = (mq.size() != 0) && out_ready;
      popped = 1'b0;
      sz     = mq.size();
      if (hs) begin
        m_beat++;
        if (m_beat == 3) begin
          m_beat = 0;
          popped = 1'b1;
          void'(mq.pop_front());
        end
      end
      cap = trace_en && inst_retire[69] && (inst_retire[68:64] != 5'd0);
      if (cap) begin
        if (sz < DEPTH || popped) mq.push_back(inst_retire[68:0]);
        else if (m_drop != 32'hFFFF_FFFF) m_drop++;
      end
    end
  end

  initial begin
    logic [31:0] exp_beats [3];
    logic [4:0]  first_wa;
    int          hs0;
    int          n;

    sys_reset_n = 1'b0;
    inst_retire = '0;
    nz_retire   = '0;
    trace_en    = 1'b0;
    out_ready   = 1'b0;

    // Reset values.
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    tick();
    sys_reset_n = 1'b1;

    // Single retire with the sink always ready.
    tick();
    trace_en    = 1'b1;
    out_ready   = 1'b1;
    inst_retire = mk_ret(32'h0000_0100, 32'hDEAD_BEEF, 5'd5);
    @(negedge sys_clk);
    check("t1_pre_valid", out_valid, 0);
    tick();
    inst_retire = '0;
    @(negedge sys_clk);
    check("t1_hdr", out_data, 32'h0100_0005);
    check("t1_v0", out_valid, 1);
    @(negedge sys_clk);
    check("t1_pc", out_data, 32'h0000_0100);
    check("t1_last_pc", out_last, 0);
    @(negedge sys_clk);
    check("t1_data", out_data, 32'hDEAD_BEEF);
    check("t1_last", out_last, 1);
    @(negedge sys_clk);
    check("t1_done", out_valid, 0);

    // Same record with a 4-cycle stall before every beat.
    out_ready   = 1'b0;
    exp_beats[0] = 32'h0100_0005;
    exp_beats[1] = 32'h0000_0100;
    exp_beats[2] = 32'hDEAD_BEEF;
    tick();
    inst_retire = mk_ret(32'h0000_0100, 32'hDEAD_BEEF, 5'd5);
    tick();
    inst_retire = '0;
    hs0 = hs_cnt;
    for (int b = 0; b < 3; b++) begin
      repeat (4) begin
        @(negedge sys_clk);
        check("t2_stable", out_data, exp_beats[b]);
        check("t2_level", fifo_level, 1);
      end
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    @(negedge sys_clk);
    check("t2_level_after", fifo_level, 0);
    check("t2_handshakes", hs_cnt - hs0, 3);

    // x0 writes: skipped by the default instance, emitted by the SKIP_ZERO=0 instance.
    tick();
    inst_retire = mk_ret(32'h0000_0200, 32'h0000_1234, 5'd0);
    nz_retire   = mk_ret(32'h0000_0200, 32'h0000_1234, 5'd0);
    tick();
    inst_retire = '0;
    nz_retire   = '0;
    @(negedge sys_clk);
    check("t3_skip_level", fifo_level, 0);
    check("t3_nz_valid", nz_valid, 1);
    check("t3_nz_hdr", nz_data, 32'h0100_0000);

    // Overflow: 20 retires into a stalled 16-deep FIFO.
    first_wa = 5'd1;
    for (int i = 0; i < 20; i++) begin
      inst_retire = mk_ret($urandom, $urandom, 5'((i % 31) + 1));
      tick();
    end
    inst_retire = '0;
    @(negedge sys_clk);
    check("t4_level", fifo_level, 16);
    check("t4_drop", drop_cnt, 4);
    check("t4_first_hdr", out_data, {8'h01, 19'd0, first_wa});

    // Full FIFO: a retire landing on the DATA handshake is accepted.
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    inst_retire = mk_ret(32'hCAFE_0000, 32'h0BAD_F00D, 5'd17);
    tick();
    inst_retire = '0;
    @(negedge sys_clk);
    check("t5_level", fifo_level, 16);
    check("t5_drop", drop_cnt, 4);
    n = 0;
    while (mq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("t5_drained", mq.size(), 0);

    // Randomized traffic with random backpressure, then drain.
    for (int i = 0; i < 400; i++) begin
      tick();
      trace_en    = ($urandom_range(0, 9) != 0);
      out_ready   = ($urandom_range(0, 9) < 6);
      inst_retire = {($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 5'($urandom_range(0, 31)),
                     32'($urandom), 32'($urandom)};
    end
    tick();
    trace_en    = 1'b0;
    inst_retire = '0;
    out_ready   = 1'b1;
    n = 0;
    while (mq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("rand_drained", mq.size(), 0);

    // Asynchronous reset during the PC beat.
    trace_en  = 1'b1;
    out_ready = 1'b1;
    tick();
    inst_retire = mk_ret(32'h0000_0400, 32'h1111_2222, 5'd9);
    tick();
    inst_retire = '0;
    tick();
    #1;
    check("t6_in_pc", out_data, 32'h0000_0400);
    sys_reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_drop", drop_cnt, 0);
    check("t6_rst_data", out_data, 0);
    tick();
    sys_reset_n = 1'b1;
    tick();
    inst_retire = mk_ret(32'h0000_0500, 32'h3333_4444, 5'd12);
    tick();
    inst_retire = '0;
    @(negedge sys_clk);
    check("t6_new_hdr", out_data, 32'h0100_000C);
    repeat (4) tick();
    check("t6_done", mq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/retire_trace_writer.md
# retire_trace_writer

Hardware producer of the retire trace that the custom CPU bench consumes. It taps the CPU's 70-bit `inst_retire` bus and captures each qualifying register-file writeback into a small FIFO. Each record is serialized as three 32-bit beats on a valid/ready stream, for a UART or DMA drain on FPGA runs. This lets silicon runs produce records that can be diffed against the golden trace the simulator checks.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in records; power of two, at least 2.
- `SKIP_ZERO`, 1: when 1, retires writing x0 are not captured.

Ports:
- `sys_clk`, in, 1: single clock.
- `sys_reset_n`, in, 1: asynchronous, active-low reset.
- `inst_retire`, in, 70: [31:0] PC, [63:32] wdata, [68:64] waddr, [69] rf_en.
- `trace_en`, in, 1: capture enable.
- `out_valid`, out, 1: beat available.
- `out_ready`, in, 1: sink accepts beat.
- `out_data`, out, 32: beat payload.
- `out_last`, out, 1: final beat of a record.
- `drop_cnt`, out, 32: count of records lost to overflow; saturating.
- `fifo_level`, out, $clog2(DEPTH)+1: records currently stored.

## Operation
- Capture condition, evaluated each cycle: `trace_en & inst_retire[69] & (SKIP_ZERO ? waddr != 0 : 1)`.
- Stored record is {waddr, wdata, PC}, 69 bits. rf_en is implied by capture and is not stored.
- Push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
- If a capture is not accepted, the record is discarded and `drop_cnt` increments. `drop_cnt` saturates at 0xFFFFFFFF.
- Serializer FSM, states HDR → PC → DATA → HDR. It advances only on a handshake (`out_valid & out_ready`).
  - HDR: `out_data` = {8'h01, 19'd0, waddr}.
  - PC: `out_data` = PC.
  - DATA: `out_data` = wdata, `out_last` = 1.
- The FIFO head is popped on the DATA handshake. The head is never popped mid-record.
- `out_valid` = (`fifo_level` != 0). `out_data` and `out_last` are driven combinationally from the head and the current state.
- Once `out_valid` is high, `out_data` stays stable until the handshake.
- Deasserting `trace_en` stops capture only. Records already stored keep draining. The FSM never abandons a partial record.
- Reset values: FIFO empty, state HDR, `out_valid`=0, `out_last`=0, `out_data`=0, `drop_cnt`=0, `fifo_level`=0.
- Reset takes effect immediately and asynchronously, including mid-record; the partial record is discarded.

## Timing
- Capture latency is 1 cycle. A retire sampled at edge k makes `out_valid` high in the cycle after edge k if the FIFO was empty.
- Throughput is one beat per cycle under constant `out_ready`. A record takes 3 cycles.
- Back-to-back records have no bubble: HDR of record n+1 follows DATA of record n directly.
- Full with a simultaneous DATA handshake: the push is accepted and `fifo_level` is unchanged.
- Empty with a simultaneous capture: there is no bypass. `out_valid` rises the next cycle.
- `fifo_level` is registered and updates at the edge of each push/pop.
- Pointers wrap modulo DEPTH. Full is detected via an extra pointer bit.

## Structure
- Package `retire_trace_pkg` holds:
  - field offsets: `RT_PC_LSB`=0, `RT_WDATA_LSB`=32, `RT_WADDR_LSB`=64, `RT_EN_BIT`=69;
  - `TRACE_TYPE_RF`=8'h01;
  - beat-state enum {HDR, PC, DATA}.
- Sub-module `trace_fifo`: synchronous FIFO, parameterized width/depth, with async active-low reset on pointers. The top level holds the capture qualifier, the FSM, and the drop counter.

## Test plan
- Single retire PC=0x0000_0100, waddr=5, wdata=0xDEADBEEF, `out_ready`=1 → beats 0x01000005, 0x00000100, 0xDEADBEEF on consecutive cycles, `out_last` on the third; `out_valid` starts 1 cycle after capture.
- Same record with `out_ready` low for 4 cycles on each beat → `out_data` stays stable while stalled; exactly 3 handshakes; `fifo_level` 1→0 only after the third.
- Retire with waddr=0 and `SKIP_ZERO`=1 → nothing captured; `fifo_level` stays 0. With `SKIP_ZERO`=0 → header 0x01000000 is emitted.
- DEPTH=16, `out_ready`=0, 20 consecutive retires → `fifo_level`=16, `drop_cnt`=4. Drain afterwards yields the first 16 records in order.
- FIFO full, a retire coincides with the DATA handshake → capture accepted, `drop_cnt` unchanged, `fifo_level` stays 16.
- `sys_reset_n` asserted asynchronously during the PC beat → `out_valid`=0, `fifo_level`=0, `drop_cnt`=0 before the next edge. After release, a new retire emits from HDR.
